// File: rtl/aurora_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aurora_pkg
//  Description : Shared types and constants for the fetch path: machine
//                width, instruction-memory address width, the end-of-program
//                word, the buffered fetch entry and the fetch FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package aurora_pkg;

    localparam int          XLEN      = 32;
    localparam int          IMEM_AW   = 8;
    localparam logic [31:0] INST_HALT = 32'h0000_0000;

    // One buffered fetch result: where it came from and what was read
    typedef struct packed {
        logic [IMEM_AW-1:0] pc;
        logic [XLEN-1:0]    inst;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        IFU_RUN  = 1'b0,
        IFU_HALT = 1'b1
    } ifu_state_e;

endpackage : aurora_pkg
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fifo
//  Description : DEPTH-entry synchronous FIFO holding fetch entries.
//                Push and pop may coincide (also when full); flush empties
//                the buffer and overrides any push/pop in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_fifo
    import aurora_pkg::*;
#(
    parameter int WIDTH = $bits(fetch_entry_t),
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    // Guard against underflow/overflow even if the caller misbehaves
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != CW'(DEPTH)) || w_pop);

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;
    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);

    // Storage array: data only, validity is tracked by the count
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : ifu_fifo
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_unit
//  Description : Instruction fetch stage. Drives the ROM word address from
//                the PC, buffers {pc, inst} in a small FIFO and hands entries
//                to decode over valid/ready. Branch redirects flush the
//                buffer and reload the PC; an all-zero word halts fetch.
//                Optional feature macro: IFU_PERF_COUNTERS_EN adds the
//                saturating fetch_count / stall_count outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
    import aurora_pkg::*;
#(
    parameter int AW           = IMEM_AW,
    parameter int DW           = XLEN,
    parameter int DEPTH        = 2,
    parameter int RESET_PC     = 0,
    parameter int HALT_ON_ZERO = 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] mem_address,
    input  logic [DW-1:0] mem_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_inst,
    output logic [AW-1:0] out_pc,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          halted
`ifdef IFU_PERF_COUNTERS_EN
    ,
    output logic [15:0]   fetch_count,
    output logic [15:0]   stall_count
`endif
);

    localparam int          CW         = $clog2(DEPTH + 1);
    localparam int          EW         = AW + DW;
    localparam logic        C_HALT_ZERO = (HALT_ON_ZERO != 0);
    localparam logic [DW-1:0] C_HALT_WORD = DW'(INST_HALT);

    logic [AW-1:0]  r_pc;
    ifu_state_e     r_state;
    logic           r_halted;
    logic [EW-1:0]  r_hold;

    logic           w_pop;
    logic           w_push;
    logic           w_space;
    logic           w_zero;
    logic [EW-1:0]  w_head;
    logic [CW-1:0]  w_count;
    logic           w_full;
    logic           w_empty;

    assign mem_address = r_pc;
    assign out_valid   = (w_count != '0);
    assign halted      = r_halted;

    assign w_zero  = C_HALT_ZERO && (mem_data == C_HALT_WORD);
    assign w_pop   = out_valid && out_ready;
    assign w_space = !w_full || w_pop;
    assign w_push  = (r_state == IFU_RUN) && !redirect_valid && w_space && !w_zero;

    ifu_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop && !redirect_valid),
        .flush   (redirect_valid),
        .wr_data ({r_pc, mem_data}),
        .rd_data (w_head),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    // PC and RUN/HALT control; a redirect overrides everything else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= AW'(RESET_PC);
            r_state  <= IFU_RUN;
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_state  <= IFU_RUN;
            r_halted <= 1'b0;
        end else if (w_push) begin
            r_pc     <= r_pc + 1'b1;
        end else if ((r_state == IFU_RUN) && w_space && w_zero) begin
            r_state  <= IFU_HALT;
            r_halted <= 1'b1;
        end
    end

    // Remember the last presented head so the outputs hold once the buffer drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (!w_empty) begin
            r_hold <= w_head;
        end
    end

    assign {out_pc, out_inst} = w_empty ? r_hold : w_head;

`ifdef IFU_PERF_COUNTERS_EN
    logic [15:0] r_fetch_count;
    logic [15:0] r_stall_count;

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_push && (r_fetch_count != 16'hFFFF)) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end
            if (out_valid && !out_ready && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule : inst_fetch_unit
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_unit
//  Description : Self-checking bench for inst_fetch_unit. A queue-based
//                model of the fetch stage predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam int DEPTH = 2;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mem_address;
    logic [31:0] mem_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [7:0]  out_pc;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        halted;
`ifdef IFU_PERF_COUNTERS_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    logic [31:0] rom [256];
    assign mem_data = rom[mem_address];

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
`ifdef IFU_PERF_COUNTERS_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    ent_t        q[$];
    ent_t        m_last;
    logic [7:0]  m_pc;
    logic        m_halt;
    logic [15:0] m_fc;
    logic [15:0] m_sc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = '{pc: 8'h00, inst: 32'h0};
        m_pc   = 8'h00;
        m_halt = 1'b0;
        m_fc   = 16'h0;
        m_sc   = 16'h0;
    endtask

    // Assert reset between edges, check the cleared outputs, release after one edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        #1;
        model_reset();
        chk("rst_valid",  32'(out_valid), 32'h0);
        chk("rst_halted", 32'(halted),    32'h0);
        chk("rst_pc",     32'(out_pc),    32'h0);
        chk("rst_inst",   out_inst,       32'h0);
        chk("rst_addr",   32'(mem_address), 32'h0);
`ifdef IFU_PERF_COUNTERS_EN
        chk("rst_fcnt",   32'(fetch_count), 32'h0);
        chk("rst_scnt",   32'(stall_count), 32'h0);
`endif
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // One clock: drive inputs, compare all outputs with the model, advance the model
    task automatic cycle(input logic rdy, input logic rv, input logic [7:0] rpc);
        logic exp_valid;
        logic pop;
        logic space;
        ent_t head;
        @(negedge clk);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        exp_valid = (q.size() != 0);
        head      = exp_valid ? q[0] : m_last;
        chk("mem_address", 32'(mem_address), 32'(m_pc));
        chk("out_valid",   32'(out_valid),   32'(exp_valid));
        chk("out_pc",      32'(out_pc),      32'(head.pc));
        chk("out_inst",    out_inst,         head.inst);
        chk("halted",      32'(halted),      32'(m_halt));
`ifdef IFU_PERF_COUNTERS_EN
        chk("fetch_count", 32'(fetch_count), 32'(m_fc));
        chk("stall_count", 32'(stall_count), 32'(m_sc));
`endif
        pop = exp_valid && rdy;
        if (exp_valid) m_last = q[0];
        if (exp_valid && !rdy && m_sc != 16'hFFFF) m_sc++;
        if (rv) begin
            q.delete();
            m_pc   = rpc;
            m_halt = 1'b0;
        end else begin
            space = (q.size() < DEPTH) || pop;
            if (pop) void'(q.pop_front());
            if (!m_halt && space) begin
                if (rom[m_pc] == 32'h0) begin
                    m_halt = 1'b1;
                end else begin
                    q.push_back('{pc: m_pc, inst: rom[m_pc]});
                    m_pc++;
                    if (m_fc != 16'hFFFF) m_fc++;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'h1000_0000 + 32'(i);
        rom[0] = 32'h83;
        rom[1] = 32'h8103;
        rom[2] = 32'h10183;
        rom[3] = 32'h0;

        // Straight-line program ending in the halt word
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h00);

        // Decode stalled from reset: buffer fills, then drains in order
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'h00);

        // Redirect while full with decode ready: head is discarded
        rom[3] = 32'h3333;
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h10);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);

        // Halt, then restart from address 0 with a redirect
        rom[3] = 32'h0;
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);

        // PC wrap from the top of the address space
        cycle(1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);

        // Randomized program, back-pressure and redirects, with one mid-run reset
        for (int i = 0; i < 256; i++)
            rom[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0,
                  8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_inst_fetch_unit
`default_nettype wire
